// File: rtl/rf_write_ctrl_if.sv
// Writeback handshake between the execute stage (master) and the RF write controller (slave).
interface rf_write_ctrl_if #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_W    = 2
);
   logic                 in_valid;
   logic                 in_ready;
   logic [ADDR_W-1:0]    in_addr;
   logic [WORD_SIZE-1:0] in_data;

   modport master (output in_valid, output in_addr, output in_data, input in_ready);
   modport slave  (input in_valid, input in_addr, input in_data, output in_ready);
endinterface

// File: rtl/rf_write_ctrl.sv
// Write-side controller for the 4 x 16-bit register file: 2-entry FIFO, registered write port, read-hazard detection.
// Optional forwarding of pending data to the read ports is enabled by defining RF_FWD_EN; otherwise hazards stall.
module rf_write_ctrl #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_W    = 2,
   parameter int DEPTH     = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   rf_write_ctrl_if.slave       wb,
   input  logic                 port_busy_i,
   output logic                 rf_write_o,
   output logic [ADDR_W-1:0]    rf_addr3_o,
   output logic [WORD_SIZE-1:0] rf_data3_o,
   input  logic                 rd_en1_i,
   input  logic                 rd_en2_i,
   input  logic [ADDR_W-1:0]    rd_addr1_i,
   input  logic [ADDR_W-1:0]    rd_addr2_i,
   output logic                 fwd1_hit_o,
   output logic                 fwd2_hit_o,
   output logic [WORD_SIZE-1:0] fwd1_data_o,
   output logic [WORD_SIZE-1:0] fwd2_data_o,
   output logic                 stall_o,
   output logic [1:0]           count_o
);
   localparam logic [1:0] FULL = 2'(DEPTH);

   logic [ADDR_W-1:0]    addr_q [2];
   logic [WORD_SIZE-1:0] data_q [2];
   logic                 head_q, head_d;
   logic                 tail_q, tail_d;
   logic [1:0]           count_q, count_d;
   logic                 wr_q, wr_d;
   logic [ADDR_W-1:0]    waddr_q, waddr_d;
   logic [WORD_SIZE-1:0] wdata_q, wdata_d;

   logic ready, push, pop, young_idx, nonempty;
   logic [2:0] match1, match2;

   // Bit 2 = youngest queued entry, bit 1 = head entry, bit 0 = output stage.
   function automatic logic [2:0] hazard_vec(input logic en, input logic [ADDR_W-1:0] ra,
                                             input logic qv, input logic [ADDR_W-1:0] ya,
                                             input logic [ADDR_W-1:0] ha, input logic ov,
                                             input logic [ADDR_W-1:0] oa);
      hazard_vec[2] = en && qv && (ya == ra);
      hazard_vec[1] = en && qv && (ha == ra);
      hazard_vec[0] = en && ov && (oa == ra);
   endfunction

   assign ready     = reset_n && (count_q < FULL);
   assign push      = wb.in_valid && ready;
   assign nonempty  = (count_q != 2'd0);
   assign pop       = nonempty && !port_busy_i;
   assign young_idx = ~tail_q;

   assign wb.in_ready = ready;
   assign count_o     = count_q;
   assign rf_write_o  = wr_q;
   assign rf_addr3_o  = waddr_q;
   assign rf_data3_o  = wdata_q;

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      wr_d    = 1'b0;
      waddr_d = waddr_q;
      wdata_d = wdata_q;
      if (pop) begin
         wr_d    = 1'b1;
         waddr_d = addr_q[head_q];
         wdata_d = data_q[head_q];
         head_d  = ~head_q;
      end
      if (push) tail_d = ~tail_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         head_q  <= 1'b0;
         tail_q  <= 1'b0;
         count_q <= 2'd0;
         wr_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         wr_q    <= wr_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   // Queue storage needs no reset: occupancy alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= wb.in_addr;
         data_q[tail_q] <= wb.in_data;
      end
   end

   assign match1 = hazard_vec(rd_en1_i, rd_addr1_i, nonempty, addr_q[young_idx], addr_q[head_q], wr_q, waddr_q);
   assign match2 = hazard_vec(rd_en2_i, rd_addr2_i, nonempty, addr_q[young_idx], addr_q[head_q], wr_q, waddr_q);

`ifdef RF_FWD_EN
   // Youngest match wins so a reader always sees the value that will land last.
   function automatic logic [WORD_SIZE-1:0] fwd_pick(input logic [2:0] m,
                                                     input logic [WORD_SIZE-1:0] yd,
                                                     input logic [WORD_SIZE-1:0] hd,
                                                     input logic [WORD_SIZE-1:0] od);
      if (m[2])      fwd_pick = yd;
      else if (m[1]) fwd_pick = hd;
      else if (m[0]) fwd_pick = od;
      else           fwd_pick = '0;
   endfunction

   assign fwd1_hit_o  = |match1;
   assign fwd2_hit_o  = |match2;
   assign fwd1_data_o = fwd_pick(match1, data_q[young_idx], data_q[head_q], wdata_q);
   assign fwd2_data_o = fwd_pick(match2, data_q[young_idx], data_q[head_q], wdata_q);
   assign stall_o     = 1'b0;
`else
   assign fwd1_hit_o  = 1'b0;
   assign fwd2_hit_o  = 1'b0;
   assign fwd1_data_o = '0;
   assign fwd2_data_o = '0;
   assign stall_o     = (|match1) || (|match2);
`endif
endmodule

// File: tb/tb_rf_write_ctrl.sv
// Self-checking bench for rf_write_ctrl: directed scenarios plus random traffic against a queue-based reference model.
`timescale 1ns/1ps
module tb_rf_write_ctrl;
   logic        clk = 1'b0;
   logic        reset_n, port_busy, rd_en1, rd_en2;
   logic [1:0]  rd_addr1, rd_addr2, rf_addr3, count;
   logic        rf_write, fwd1_hit, fwd2_hit, stall;
   logic [15:0] rf_data3, fwd1_data, fwd2_data;

   always #5 clk = ~clk;

   rf_write_ctrl_if #(.WORD_SIZE(16), .ADDR_W(2)) wbif ();

   rf_write_ctrl #(.WORD_SIZE(16), .ADDR_W(2), .DEPTH(2)) dut (
      .clk(clk), .reset_n(reset_n), .wb(wbif), .port_busy_i(port_busy),
      .rf_write_o(rf_write), .rf_addr3_o(rf_addr3), .rf_data3_o(rf_data3),
      .rd_en1_i(rd_en1), .rd_en2_i(rd_en2), .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
      .fwd1_hit_o(fwd1_hit), .fwd2_hit_o(fwd2_hit), .fwd1_data_o(fwd1_data), .fwd2_data_o(fwd2_data),
      .stall_o(stall), .count_o(count)
   );

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct packed { logic [1:0] addr; logic [15:0] data; } wr_t;
   wr_t  mq[$];
   logic m_wr = 1'b0;
   wr_t  m_out = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pending writes listed youngest first; first address match is the visible one.
   function automatic logic [16:0] ref_hazard(input logic en, input logic [1:0] ra);
      wr_t pend[$];
      for (int i = mq.size() - 1; i >= 0; i--) pend.push_back(mq[i]);
      if (m_wr) pend.push_back(m_out);
      if (en) foreach (pend[i]) if (pend[i].addr == ra) return {1'b1, pend[i].data};
      return 17'd0;
   endfunction

   task automatic check_all();
      logic [16:0] h1, h2;
      h1 = ref_hazard(rd_en1, rd_addr1);
      h2 = ref_hazard(rd_en2, rd_addr2);
      chk("in_ready", 32'(wbif.in_ready), 32'(reset_n && mq.size() < 2));
      chk("count", 32'(count), 32'(mq.size()));
      chk("rf_write", 32'(rf_write), 32'(m_wr));
      chk("rf_addr3", 32'(rf_addr3), 32'(m_out.addr));
      chk("rf_data3", 32'(rf_data3), 32'(m_out.data));
`ifdef RF_FWD_EN
      chk("fwd1_hit", 32'(fwd1_hit), 32'(h1[16]));
      chk("fwd1_data", 32'(fwd1_data), 32'(h1[15:0]));
      chk("fwd2_hit", 32'(fwd2_hit), 32'(h2[16]));
      chk("fwd2_data", 32'(fwd2_data), 32'(h2[15:0]));
      chk("stall", 32'(stall), 32'd0);
`else
      chk("fwd1_hit", 32'(fwd1_hit), 32'd0);
      chk("fwd1_data", 32'(fwd1_data), 32'd0);
      chk("fwd2_hit", 32'(fwd2_hit), 32'd0);
      chk("fwd2_data", 32'(fwd2_data), 32'd0);
      chk("stall", 32'(stall), 32'(h1[16] | h2[16]));
`endif
   endtask

   task automatic model_update();
      if (!reset_n) begin
         mq.delete();
         m_wr  = 1'b0;
         m_out = '0;
      end else begin
         bit acc;
         acc = wbif.in_valid && (mq.size() < 2);
         if (mq.size() > 0 && !port_busy) begin
            m_out = mq.pop_front();
            m_wr  = 1'b1;
         end else begin
            m_wr = 1'b0;
         end
         if (acc) mq.push_back(wr_t'{addr: wbif.in_addr, data: wbif.in_data});
      end
   endtask

   // Inputs change at negedge; outputs are checked shortly after, well clear of posedge.
   task automatic tick();
      #1 check_all();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic push(input logic [1:0] a, input logic [15:0] d);
      wbif.in_valid = 1'b1;
      wbif.in_addr  = a;
      wbif.in_data  = d;
      tick();
      wbif.in_valid = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; port_busy = 1'b0;
      rd_en1 = 1'b0; rd_en2 = 1'b0; rd_addr1 = 2'd0; rd_addr2 = 2'd0;
      wbif.in_valid = 1'b0; wbif.in_addr = 2'd0; wbif.in_data = 16'd0;
      @(posedge clk);
      model_update();
      @(negedge clk);
      tick();
      reset_n = 1'b1;

      // Single write: latency two edges, one-cycle strobe
      push(2'd2, 16'hBEEF);
      chk("t1_cnt_after_push", 32'(count), 32'd1);
      chk("t1_wr_not_yet", 32'(rf_write), 32'd0);
      tick();
      chk("t1_wr", 32'(rf_write), 32'd1);
      chk("t1_addr", 32'(rf_addr3), 32'd2);
      chk("t1_data", 32'(rf_data3), 32'hBEEF);
      tick();
      chk("t1_wr_done", 32'(rf_write), 32'd0);
      chk("t1_cnt_done", 32'(count), 32'd0);

      // Port busy: fill, third request blocked, then drain in order
      port_busy = 1'b1;
      push(2'd1, 16'h1111);
      push(2'd3, 16'h2222);
      chk("t2_cnt_full", 32'(count), 32'd2);
      chk("t2_not_ready", 32'(wbif.in_ready), 32'd0);
      push(2'd0, 16'h3333);
      chk("t2_third_rejected", 32'(count), 32'd2);
      port_busy = 1'b0;
      tick();
      chk("t2_first_wr", 32'(rf_write), 32'd1);
      chk("t2_first_addr", 32'(rf_addr3), 32'd1);
      chk("t2_first_data", 32'(rf_data3), 32'h1111);
      tick();
      chk("t2_second_wr", 32'(rf_write), 32'd1);
      chk("t2_second_addr", 32'(rf_addr3), 32'd3);
      chk("t2_second_data", 32'(rf_data3), 32'h2222);
      tick();
      chk("t2_idle", 32'(rf_write), 32'd0);

      // Two pending writes to r0: youngest value must be visible
      port_busy = 1'b1;
      push(2'd0, 16'h00AA);
      push(2'd0, 16'h00BB);
      rd_en1 = 1'b1; rd_addr1 = 2'd0;
      #1;
`ifdef RF_FWD_EN
      chk("t3_fwd_hit", 32'(fwd1_hit), 32'd1);
      chk("t3_fwd_data", 32'(fwd1_data), 32'h00BB);
`else
      chk("t3_stall", 32'(stall), 32'd1);
`endif
      port_busy = 1'b0;
      repeat (3) tick();
      rd_en1 = 1'b0;

      // Streaming at full rate
      for (int i = 0; i < 12; i++) begin
         push(2'($urandom), 16'($urandom));
         chk("t4_ready", 32'(wbif.in_ready), 32'd1);
         chk("t4_cnt_le1", 32'(count <= 2'd1), 32'd1);
         if (i > 0) chk("t4_wr", 32'(rf_write), 32'd1);
      end
      repeat (3) tick();

      // Reset while full
      port_busy = 1'b1;
      push(2'd1, 16'hA5A5);
      push(2'd2, 16'h5A5A);
      reset_n = 1'b0;
      wbif.in_valid = 1'b1;
      #1 chk("t5_ready_in_rst", 32'(wbif.in_ready), 32'd0);
      tick();
      reset_n = 1'b1; wbif.in_valid = 1'b0; port_busy = 1'b0;
      #1;
      chk("t5_cnt", 32'(count), 32'd0);
      chk("t5_ready_after", 32'(wbif.in_ready), 32'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t5_no_wr", 32'(rf_write), 32'd0);
      end

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         wbif.in_valid = ($urandom_range(0, 3) != 0);
         wbif.in_addr  = 2'($urandom);
         wbif.in_data  = 16'($urandom);
         port_busy     = ($urandom_range(0, 3) == 0);
         rd_en1        = 1'($urandom);
         rd_en2        = 1'($urandom);
         rd_addr1      = 2'($urandom);
         rd_addr2      = 2'($urandom);
         reset_n       = ($urandom_range(0, 49) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
